// File: rtl/exec_unit_pkg.sv
// Shared types and IR field layout for exec_unit_p.
//  alu_op_e      : 4-bit ALU opcode held in IR[DW-1:DW-4]; codes 14 and 15 behave as ZERO
//  fetch_state_e : fetch sequencer states
//  op_lo/w_lo/r_lo/s_lo : low bit index of each IR field, as functions of DW and AW
package exec_unit_pkg;

    typedef enum logic [3:0] {
        PASS_S = 4'd0,
        PASS_R = 4'd1,
        ADD    = 4'd2,
        SUB    = 4'd3,
        INC    = 4'd4,
        DEC    = 4'd5,
        AND    = 4'd6,
        OR     = 4'd7,
        XOR    = 4'd8,
        NOT_S  = 4'd9,
        SHL    = 4'd10,
        SHR    = 4'd11,
        ASR    = 4'd12,
        ZERO   = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

    localparam int unsigned OP_W = 4;

    function automatic int unsigned op_lo(input int unsigned dw);
        return dw - OP_W;
    endfunction

    function automatic int unsigned w_lo(input int unsigned aw);
        return 2 * aw;
    endfunction

    function automatic int unsigned r_lo(input int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned s_lo(input int unsigned aw);
        return 0 * aw;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for exec_unit_p.
// Ports:
//  op     in  alu_op_e  operation select
//  r      in  DW        R operand
//  s      in  DW        S operand (unary ops and shifts act on S)
//  result out DW        operation result
//  c      out 1         carry / borrow / shifted-out bit, 0 for logic ops
//  n, z   out 1         result MSB, result == 0
// ADD/SUB/INC/DEC produce carry-out (SUB/DEC: borrow) from a DW+1 bit sum.
module exec_alu
    import exec_unit_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  alu_op_e       op,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] s,
    output logic [DW-1:0] result,
    output logic          c,
    output logic          n,
    output logic          z
);

    logic [DW:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        c      = 1'b0;
        case (op)
            PASS_S: result = s;
            PASS_R: result = r;
            ADD: begin
                wide   = {1'b0, r} + {1'b0, s};
                result = wide[DW-1:0];
                c      = wide[DW];
            end
            SUB: begin
                // top bit of the widened difference is the borrow
                wide   = {1'b0, r} - {1'b0, s};
                result = wide[DW-1:0];
                c      = wide[DW];
            end
            INC: begin
                wide   = {1'b0, s} + (DW+1)'(1);
                result = wide[DW-1:0];
                c      = wide[DW];
            end
            DEC: begin
                wide   = {1'b0, s} - (DW+1)'(1);
                result = wide[DW-1:0];
                c      = wide[DW];
            end
            AND:   result = r & s;
            OR:    result = r | s;
            XOR:   result = r ^ s;
            NOT_S: result = ~s;
            SHL: begin
                result = {s[DW-2:0], 1'b0};
                c      = s[DW-1];
            end
            SHR: begin
                result = {1'b0, s[DW-1:1]};
                c      = s[0];
            end
            ASR: begin
                result = {s[DW-1], s[DW-1:1]};
                c      = s[0];
            end
            default: result = '0;
        endcase
        n = result[DW-1];
        z = (result == '0);
    end

endmodule

// File: rtl/exec_unit_p.sv
// Execution unit: register file, ALU, C/N/Z flags, PC, IR and a req/ack fetch sequencer.
// Optional feature macro: BRANCH_REL_EN (adds input pc_rel for PC-relative branches).
// Ports:
//  clk, reset          clock; synchronous active-low reset
//  w_en                write ALU result to reg[W] and latch C/N/Z
//  s_sel               S operand source: 1 = D_in, 0 = reg[S]
//  adr_sel             idle Address source: 1 = reg[R], 0 = PC
//  pc_ld, pc_inc       PC load from ALU / increment (idle only, pc_ld wins)
//  pc_rel              (BRANCH_REL_EN) PC += sign_ext(IR[7:0]) (idle only)
//  ir_ld               IR <= D_in (idle only)
//  fetch, mem_ack      start fetch (IDLE only) / memory data valid
//  D_in                memory read data
//  mem_req, busy       fetch request / sequencer not IDLE
//  fetch_done          one-cycle pulse after a fetch loaded IR
//  Address, D_out      memory address / combinational ALU result
//  ir_out, C, N, Z     IR contents and registered flags
module exec_unit_p
    import exec_unit_pkg::*;
#(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   RF_DEPTH = 8,
    parameter logic [DW-1:0] PC_RST   = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w_en,
    input  logic          s_sel,
    input  logic          adr_sel,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          ir_ld,
`ifdef BRANCH_REL_EN
    input  logic          pc_rel,
`endif
    input  logic          fetch,
    input  logic          mem_ack,
    input  logic [DW-1:0] D_in,
    output logic          mem_req,
    output logic          busy,
    output logic          fetch_done,
    output logic [DW-1:0] Address,
    output logic [DW-1:0] D_out,
    output logic [DW-1:0] ir_out,
    output logic          C,
    output logic          N,
    output logic          Z
);

    localparam int unsigned AW    = $clog2(RF_DEPTH);
    localparam int unsigned OP_LO = op_lo(DW);
    localparam int unsigned W_LO  = w_lo(AW);
    localparam int unsigned R_LO  = r_lo(AW);
    localparam int unsigned S_LO  = s_lo(AW);

    fetch_state_e  state, state_nx;
    logic [DW-1:0] rf [RF_DEPTH];
    logic [DW-1:0] pc, pc_nx, ir;
    logic [AW-1:0] w_idx, r_idx, s_idx;
    logic [DW-1:0] r_val, s_val;
    alu_op_e       op;
    logic          alu_c, alu_n, alu_z;
    logic          idle, ack_edge;

    assign op    = alu_op_e'(ir[OP_LO +: OP_W]);
    assign w_idx = ir[W_LO +: AW];
    assign r_idx = ir[R_LO +: AW];
    assign s_idx = ir[S_LO +: AW];

    assign r_val = rf[r_idx];
    assign s_val = s_sel ? D_in : rf[s_idx];

    exec_alu #(.DW(DW)) u_alu (
        .op     (op),
        .r      (r_val),
        .s      (s_val),
        .result (D_out),
        .c      (alu_c),
        .n      (alu_n),
        .z      (alu_z)
    );

    assign idle     = (state == IDLE);
    assign ack_edge = (state == REQ) && mem_ack;
    assign Address  = (idle && adr_sel) ? r_val : pc;
    assign ir_out   = ir;

    // Register file and flags; w_en is honoured in every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
            C <= 1'b0;
            N <= 1'b0;
            Z <= 1'b0;
        end else if (w_en) begin
            rf[w_idx] <= D_out;
            C         <= alu_c;
            N         <= alu_n;
            Z         <= alu_z;
        end
    end

    // PC source select: a completing fetch increments; otherwise idle strobes apply.
    always_comb begin
        pc_nx = pc;
        if (ack_edge) begin
            pc_nx = pc + DW'(1);
        end else if (idle) begin
            if (pc_ld) begin
                pc_nx = D_out;
`ifdef BRANCH_REL_EN
            end else if (pc_rel) begin
                pc_nx = pc + {{(DW-8){ir[7]}}, ir[7:0]};
`endif
            end else if (pc_inc) begin
                pc_nx = pc + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= PC_RST;
            ir <= '0;
        end else begin
            pc <= pc_nx;
            if (ack_edge || (idle && ir_ld)) ir <= D_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        busy       = 1'b1;
        fetch_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (fetch) state_nx = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) state_nx = DONE;
            end
            DONE: begin
                fetch_done = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exec_unit_p.sv
// Randomised scoreboard bench for exec_unit_p (DW=16, RF_DEPTH=8, PC_RST=0x0010).
// The driver updates an arithmetic reference model and queues expected output values;
// a negedge monitor pops and compares them, and separately checks every fetch_done
// pulse against a queue of expected fetched words.
`timescale 1ns/1ps
module tb_exec_unit_p;
    import exec_unit_pkg::*;

    localparam logic [15:0] PC_RST_V = 16'h0010;
    localparam int S_ADDR = 0, S_DOUT = 1, S_IR = 2, S_C = 3, S_N = 4, S_Z = 5,
                   S_BUSY = 6, S_REQ = 7, S_DONE = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_en = 1'b0, s_sel = 1'b0, adr_sel = 1'b0, pc_ld = 1'b0, pc_inc = 1'b0;
    logic        ir_ld = 1'b0, fetch = 1'b0, mem_ack = 1'b0;
`ifdef BRANCH_REL_EN
    logic        pc_rel = 1'b0;
`endif
    logic [15:0] D_in = '0;
    logic        mem_req, busy, fetch_done, C, N, Z;
    logic [15:0] Address, D_out, ir_out;

    exec_unit_p #(.DW(16), .RF_DEPTH(8), .PC_RST(PC_RST_V)) dut (
        .clk(clk), .reset(reset), .w_en(w_en), .s_sel(s_sel), .adr_sel(adr_sel),
        .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld),
`ifdef BRANCH_REL_EN
        .pc_rel(pc_rel),
`endif
        .fetch(fetch), .mem_ack(mem_ack), .D_in(D_in),
        .mem_req(mem_req), .busy(busy), .fetch_done(fetch_done),
        .Address(Address), .D_out(D_out), .ir_out(ir_out), .C(C), .N(N), .Z(Z)
    );

    always #5 clk = ~clk;

    typedef struct { int sig; int exp; string name; } chk_t;
    chk_t chk_q[$];
    int   fetch_q[$];
    int   vectors = 0, miscompares = 0;

    // reference model state
    int m_pc, m_ir, m_c, m_n, m_z;
    int m_reg[8];

    function automatic logic [15:0] actual(input int sig);
        case (sig)
            S_ADDR:  return Address;
            S_DOUT:  return D_out;
            S_IR:    return ir_out;
            S_C:     return {15'd0, C};
            S_N:     return {15'd0, N};
            S_Z:     return {15'd0, Z};
            S_BUSY:  return {15'd0, busy};
            S_REQ:   return {15'd0, mem_req};
            default: return {15'd0, fetch_done};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [15:0] a;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            a = actual(c.sig);
            vectors++;
            if (a !== 16'(c.exp)) begin
                miscompares++;
                $display("FAIL %s: actual %h required %h", c.name, a, 16'(c.exp));
            end
        end
        if (fetch_done === 1'b1) begin
            vectors++;
            if (fetch_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_fetch_done: actual 1 required 0");
            end else begin
                a = 16'(fetch_q.pop_front());
                if (ir_out !== a) begin
                    miscompares++;
                    $display("FAIL fetched_ir: actual %h required %h", ir_out, a);
                end
            end
        end
    end

    function automatic void want(input int sig, input int exp, input string name);
        chk_q.push_back('{sig, exp, name});
    endfunction

    // Reference ALU in plain integer arithmetic over 0..65535.
    function automatic void alu_ref(input int op, input int r, input int s,
                                    output int res, output int c);
        c = 0;
        case (op)
            int'(PASS_S): res = s;
            int'(PASS_R): res = r;
            int'(ADD):    begin res = (r + s) % 65536; c = (r + s) / 65536; end
            int'(SUB):    begin res = (r - s + 65536) % 65536; c = (r < s) ? 1 : 0; end
            int'(INC):    begin res = (s + 1) % 65536; c = (s == 65535) ? 1 : 0; end
            int'(DEC):    begin res = (s + 65535) % 65536; c = (s == 0) ? 1 : 0; end
            int'(AND):    res = r & s;
            int'(OR):     res = r | s;
            int'(XOR):    res = r ^ s;
            int'(NOT_S):  res = 65535 - s;
            int'(SHL):    begin res = (s * 2) % 65536; c = s / 32768; end
            int'(SHR):    begin res = s / 2; c = s % 2; end
            int'(ASR):    begin res = s / 2 + (s / 32768) * 32768; c = s % 2; end
            default:      res = 0;
        endcase
    endfunction

    function automatic int instr(input int op, input int w, input int r, input int s);
        return (op << 12) | (w << 6) | (r << 3) | s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        w_en = 0; s_sel = 0; adr_sel = 0; pc_ld = 0; pc_inc = 0;
        ir_ld = 0; fetch = 0; mem_ack = 0;
`ifdef BRANCH_REL_EN
        pc_rel = 0;
`endif
    endtask

    task automatic model_reset();
        m_pc = int'(PC_RST_V); m_ir = 0; m_c = 0; m_n = 0; m_z = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
    endtask

    // ALU result for the current model IR with the given S source.
    function automatic void cur_alu(input bit ssel, input int din, output int res, output int c);
        int sv;
        sv = ssel ? din : m_reg[m_ir & 7];
        alu_ref((m_ir >> 12) & 15, m_reg[(m_ir >> 3) & 7], sv, res, c);
    endfunction

    function automatic void commit_w(input int res, input int c);
        m_reg[(m_ir >> 6) & 7] = res;
        m_c = c; m_n = res / 32768; m_z = (res == 0) ? 1 : 0;
    endfunction

    function automatic void want_flags(input string tag);
        want(S_C, m_c, {tag, "_c"});
        want(S_N, m_n, {tag, "_n"});
        want(S_Z, m_z, {tag, "_z"});
    endfunction

    task automatic check_pc(input string name);
        adr_sel = 0;
        want(S_ADDR, m_pc, name);
    endtask

    task automatic load_ir(input int v);
        D_in = 16'(v); ir_ld = 1;
        tick();
        ir_ld = 0; m_ir = v;
    endtask

    task automatic check_reg(input int k);
        load_ir(instr(int'(PASS_R), 0, k, 0));
        adr_sel = 1;
        want(S_ADDR, m_reg[k], "reg_via_addr");
        want(S_DOUT, m_reg[k], "reg_via_dout");
        tick();
        adr_sel = 0;
    endtask

    task automatic exec(input int op, input int w, input int r, input int s,
                        input bit ssel, input int din);
        int res, c;
        load_ir(instr(op, w, r, s));
        w_en = 1; s_sel = ssel; D_in = 16'(din);
        cur_alu(ssel, din, res, c);
        want(S_DOUT, res, "exec_dout");
        tick();
        w_en = 0; s_sel = 0;
        commit_w(res, c);
        want_flags("exec");
    endtask

    // One fetch with 'waits' idle-ack cycles; 'noise' drives strobes that must be ignored
    // (and w_en, which must still execute) while the sequencer is busy.
    task automatic do_fetch(input int waits, input int data, input bit noise);
        int res, c;
        bit we;
        quiet();
        fetch = 1;
        tick();
        fetch = 0;
        for (int i = 0; i <= waits; i++) begin
            want(S_REQ, 1, "req_high");
            want(S_BUSY, 1, "busy_req");
            want(S_DONE, 0, "done_low_req");
            want(S_ADDR, m_pc, "addr_is_pc");
            we = 0;
            if (noise) begin
                adr_sel = 1; pc_inc = 1'($urandom); ir_ld = 1'($urandom);
                pc_ld = 1'($urandom); fetch = 1'($urandom);
                s_sel = 1'($urandom); D_in = 16'($urandom);
                we = 1'($urandom);
            end
            if (i == waits) begin
                mem_ack = 1; D_in = 16'(data);
            end
            w_en = we;
            cur_alu(s_sel, int'(D_in), res, c);
            tick();
            if (we) commit_w(res, c);
            quiet();
        end
        m_ir = data; m_pc = (m_pc + 1) % 65536;
        fetch_q.push_back(data);
        fetch = 1; mem_ack = 1; D_in = 16'($urandom);
        want(S_BUSY, 1, "busy_done");
        want(S_REQ, 0, "req_low_done");
        want(S_DONE, 1, "done_pulse");
        want(S_IR, m_ir, "ir_after_fetch");
        want_flags("fetch");
        tick();
        quiet();
        want(S_BUSY, 0, "busy_back_idle");
        want(S_DONE, 0, "done_one_cycle");
        check_pc("pc_after_fetch");
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int res, c, sel;
        quiet();
        // 1. reset
        reset = 0;
        tick(); tick();
        model_reset();
        want(S_BUSY, 0, "rst_busy");
        want(S_REQ, 0, "rst_req");
        want(S_DONE, 0, "rst_done");
        want(S_IR, 0, "rst_ir");
        want_flags("rst");
        check_pc("rst_pc");
        tick();
        reset = 1;
        check_pc("rst_pc_released");
        tick();
        for (int k = 0; k < 8; k++) check_reg(k);

        // 2. fetch with 3 wait states from PC 0x0010
        want(S_ADDR, 16'h0010, "pc_before_fetch");
        do_fetch(3, 16'h2A4C, 0);
        want(S_IR, 16'h2A4C, "fetch_ir_const");
        want(S_ADDR, 16'h0011, "fetch_pc_const");
        tick();

        // 3. ADD carry into zero
        exec(int'(PASS_S), 1, 0, 0, 1, 16'hFFFF);
        exec(int'(PASS_S), 2, 0, 0, 1, 16'h0001);
        exec(int'(ADD), 3, 1, 2, 0, 0);
        want(S_C, 1, "add_c_const");
        want(S_Z, 1, "add_z_const");
        want(S_N, 0, "add_n_const");
        tick();
        check_reg(3);

        // 4. PC wrap and pc_ld priority
        load_ir(instr(int'(PASS_S), 0, 0, 0));
        s_sel = 1; D_in = 16'hFFFF; pc_ld = 1;
        tick();
        quiet(); m_pc = 16'hFFFF;
        check_pc("pc_ld_ffff");
        pc_inc = 1;
        tick();
        quiet(); m_pc = 0;
        want(S_ADDR, 0, "pc_wrap");
        pc_ld = 1; pc_inc = 1; s_sel = 1; D_in = 16'h1234;
        tick();
        quiet(); m_pc = 16'h1234;
        want(S_ADDR, 16'h1234, "pc_ld_wins");
        tick();

        // 5. busy lockout and reset mid-fetch
        fetch = 1;
        tick();
        fetch = 0; ir_ld = 1; pc_inc = 1; D_in = 16'hBEEF;
        tick();
        quiet();
        want(S_REQ, 1, "lock_req");
        want(S_ADDR, m_pc, "lock_pc");
        want(S_IR, m_ir, "lock_ir");
        reset = 0;
        tick();
        reset = 1;
        model_reset();
        want(S_REQ, 0, "midrst_req");
        want(S_BUSY, 0, "midrst_busy");
        want(S_DONE, 0, "midrst_done");
        want(S_IR, 0, "midrst_ir");
        check_pc("midrst_pc");
        for (int i = 0; i < 3; i++) begin
            tick();
            want(S_DONE, 0, "midrst_no_pulse");
        end
        tick();

`ifdef BRANCH_REL_EN
        // 6. relative branch backwards by 2
        load_ir(16'h00FE);
        s_sel = 1; D_in = 16'h0100; pc_ld = 1;
        tick();
        quiet(); m_pc = 16'h0100;
        pc_rel = 1; pc_inc = 1;
        tick();
        quiet(); m_pc = 16'h00FE;
        want(S_ADDR, 16'h00FE, "pc_rel");
        tick();
`endif

        // random mix
        for (int it = 0; it < 120; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 4) begin
                exec(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     1'($urandom), int'($urandom_range(0, 65535)));
            end else if (sel <= 6) begin
                check_reg(int'($urandom_range(0, 7)));
            end else if (sel == 7) begin
                do_fetch(int'($urandom_range(0, 4)), int'($urandom_range(0, 65535)), 1);
            end else begin
                s_sel = 1; D_in = 16'($urandom);
                pc_ld = 1'($urandom); pc_inc = 1'($urandom); mem_ack = 1'($urandom);
                cur_alu(1, int'(D_in), res, c);
                if (pc_ld) m_pc = res;
                else if (pc_inc) m_pc = (m_pc + 1) % 65536;
                tick();
                quiet();
                want(S_BUSY, 0, "ack_idle_ignored");
                check_pc("rand_pc");
                tick();
            end
        end

        tick(); tick();
        vectors++;
        if (fetch_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_fetch_done: actual %0d pending required 0", fetch_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
